// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: PC-source encodings,
// the NOP word, FSM states and the IF/ID payload.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  // id_if_selpctype encodings
  localparam logic [1:0] PCT_BR  = 2'b00;
  localparam logic [1:0] PCT_JR  = 2'b01;
  localparam logic [1:0] PCT_J   = 2'b10;
  localparam logic [1:0] PCT_EXC = 2'b11;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instruc;
    logic [XLEN-1:0] nextpc;
  } if_id_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection for the fetch stage (purely combinational).
// Ports:
//   selpcsource, selpctype, rega, pcimd2ext, pcindex : redirect request from decode
//   stall            : execute stall; a redirect under stall is ignored
//   pc               : current fetch PC
//   redir_pending, redir_pc : redirect captured earlier, not yet applied
//   target_c         : selected redirect target
//   seq_c            : pc + 4 (wraps at 2^32)
//   redirect_c       : a redirect is accepted this cycle
//   next_pc_c        : PC to load when the current fetch completes
module fetch_next_pc
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic             selpcsource,
  input  logic [1:0]       selpctype,
  input  logic [XLEN-1:0]  rega,
  input  logic [XLEN-1:0]  pcimd2ext,
  input  logic [XLEN-1:0]  pcindex,
  input  logic             stall,
  input  logic [XLEN-1:0]  pc,
  input  logic             redir_pending,
  input  logic [XLEN-1:0]  redir_pc,
  output logic [XLEN-1:0]  target_c,
  output logic [XLEN-1:0]  seq_c,
  output logic             redirect_c,
  output logic [XLEN-1:0]  next_pc_c
);

  // Target mux
  always_comb begin
    target_c = pcimd2ext;
    case (selpctype)
      PCT_BR:  target_c = pcimd2ext;
      PCT_JR:  target_c = rega;
      PCT_J:   target_c = pcindex;
      PCT_EXC: target_c = EXC_VECTOR;
      default: target_c = pcimd2ext;
    endcase
  end

  // A fresh redirect beats an older pending one, which beats sequential flow
  always_comb begin
    seq_c      = pc + XLEN'(4);
    redirect_c = selpcsource & ~stall;
    next_pc_c  = seq_c;
    if (redirect_c) begin
      next_pc_c = target_c;
    end else if (redir_pending) begin
      next_pc_c = redir_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: holds the PC, issues word reads to the memory
// controller, and produces the IF/ID register. Redirects from decode take
// effect after the in-flight (delay-slot) fetch completes; nothing is flushed.
// Optional macro IF_PERF_CNT_EN adds fetched/bubble performance counters.
// Ports:
//   clock, reset (async, active-low)
//   ex_if_stall                 : freeze PC and IF/ID
//   id_if_selpcsource/_selpctype/_rega/_pcimd2ext/_pcindex : redirect from decode
//   mc_if_data, mc_if_valid     : memory read response
//   if_mc_en, if_mc_addr        : memory read request (word address)
//   if_id_instruc, if_id_nextpc : IF/ID register
//   if_perf_fetched, if_perf_bubbles : counters (IF_PERF_CNT_EN only)
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0]  RESET_PC   = 32'h0000_0000,
  parameter logic [31:0]  EXC_VECTOR = 32'h0000_0080,
  parameter int unsigned  ADDR_W     = 18
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_if_stall,
  input  logic              id_if_selpcsource,
  input  logic [1:0]        id_if_selpctype,
  input  logic [XLEN-1:0]   id_if_rega,
  input  logic [XLEN-1:0]   id_if_pcimd2ext,
  input  logic [XLEN-1:0]   id_if_pcindex,
  input  logic [XLEN-1:0]   mc_if_data,
  input  logic              mc_if_valid,
  output logic              if_mc_en,
  output logic [ADDR_W-1:0] if_mc_addr,
  output logic [XLEN-1:0]   if_id_instruc,
`ifdef IF_PERF_CNT_EN
  output logic [XLEN-1:0]   if_perf_fetched,
  output logic [XLEN-1:0]   if_perf_bubbles,
`endif
  output logic [XLEN-1:0]   if_id_nextpc
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  if_id_t          if_id_q, if_id_d;
  logic [XLEN-1:0] hold_data_q, hold_data_d;
  logic            redir_pending_q, redir_pending_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic            en_q, en_d;
  logic            deliver_c;
  logic            bubble_c;

  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] seq_c;
  logic            redirect_c;
  logic [XLEN-1:0] next_pc_c;

  fetch_next_pc #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_pc (
    .selpcsource   (id_if_selpcsource),
    .selpctype     (id_if_selpctype),
    .rega          (id_if_rega),
    .pcimd2ext     (id_if_pcimd2ext),
    .pcindex       (id_if_pcindex),
    .stall         (ex_if_stall),
    .pc            (pc_q),
    .redir_pending (redir_pending_q),
    .redir_pc      (redir_pc_q),
    .target_c      (target_c),
    .seq_c         (seq_c),
    .redirect_c    (redirect_c),
    .next_pc_c     (next_pc_c)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= BOOT;
      pc_q            <= RESET_PC;
      if_id_q         <= '{instruc: NOP, nextpc: '0};
      hold_data_q     <= '0;
      redir_pending_q <= 1'b0;
      redir_pc_q      <= '0;
      en_q            <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      if_id_q         <= if_id_d;
      hold_data_q     <= hold_data_d;
      redir_pending_q <= redir_pending_d;
      redir_pc_q      <= redir_pc_d;
      en_q            <= en_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    if_id_d         = if_id_q;
    hold_data_d     = hold_data_q;
    redir_pending_d = redir_pending_q;
    redir_pc_d      = redir_pc_q;
    deliver_c       = 1'b0;
    bubble_c        = 1'b0;

    // Capture first; a completing fetch below consumes and clears it
    if (redirect_c) begin
      redir_pending_d = 1'b1;
      redir_pc_d      = target_c;
    end

    case (state_q)
      BOOT: begin
        state_d = REQ;
      end
      REQ: begin
        if (mc_if_valid) begin
          if (!ex_if_stall) begin
            if_id_d         = '{instruc: mc_if_data, nextpc: seq_c};
            pc_d            = next_pc_c;
            redir_pending_d = 1'b0;
            deliver_c       = 1'b1;
          end else begin
            // Park the returned word so the request is not repeated
            hold_data_d = mc_if_data;
            state_d     = HOLD;
          end
        end else if (!ex_if_stall) begin
          if_id_d.instruc = NOP;
          bubble_c        = 1'b1;
        end
      end
      HOLD: begin
        if (!ex_if_stall) begin
          if_id_d         = '{instruc: hold_data_q, nextpc: seq_c};
          pc_d            = next_pc_c;
          redir_pending_d = 1'b0;
          deliver_c       = 1'b1;
          state_d         = REQ;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    en_d = (state_d == REQ);
  end

  assign if_mc_en      = en_q;
  assign if_mc_addr    = pc_q[ADDR_W+1:2];
  assign if_id_instruc = if_id_q.instruc;
  assign if_id_nextpc  = if_id_q.nextpc;

`ifdef IF_PERF_CNT_EN
  logic [XLEN-1:0] perf_fetched_q;
  logic [XLEN-1:0] perf_bubbles_q;

  // Delivered-instruction and bubble counters, free-running with wrap
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      if (deliver_c) perf_fetched_q <= perf_fetched_q + XLEN'(1);
      if (bubble_c)  perf_bubbles_q <= perf_bubbles_q + XLEN'(1);
    end
  end

  assign if_perf_fetched = perf_fetched_q;
  assign if_perf_bubbles = perf_bubbles_q;
`else
  logic unused_perf;
  assign unused_perf = deliver_c ^ bubble_c;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes hand-computed IF/ID and
// request expectations; a monitor pops and compares on each falling edge.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int unsigned AW = 18;

  logic          clock;
  logic          reset;
  logic          ex_if_stall;
  logic          id_if_selpcsource;
  logic [1:0]    id_if_selpctype;
  logic [31:0]   id_if_rega;
  logic [31:0]   id_if_pcimd2ext;
  logic [31:0]   id_if_pcindex;
  logic [31:0]   mc_if_data;
  logic          mc_if_valid;
  logic          if_mc_en;
  logic [AW-1:0] if_mc_addr;
  logic [31:0]   if_id_instruc;
  logic [31:0]   if_id_nextpc;
`ifdef IF_PERF_CNT_EN
  logic [31:0]   if_perf_fetched;
  logic [31:0]   if_perf_bubbles;
`endif

  typedef struct packed {
    logic [31:0]   instr;
    logic [31:0]   npc;
    logic          en;
    logic [AW-1:0] addr;
    logic [31:0]   fetched;
    logic [31:0]   bubbles;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  fetch_stage dut (
    .clock             (clock),
    .reset             (reset),
    .ex_if_stall       (ex_if_stall),
    .id_if_selpcsource (id_if_selpcsource),
    .id_if_selpctype   (id_if_selpctype),
    .id_if_rega        (id_if_rega),
    .id_if_pcimd2ext   (id_if_pcimd2ext),
    .id_if_pcindex     (id_if_pcindex),
    .mc_if_data        (mc_if_data),
    .mc_if_valid       (mc_if_valid),
    .if_mc_en          (if_mc_en),
    .if_mc_addr        (if_mc_addr),
    .if_id_instruc     (if_id_instruc),
`ifdef IF_PERF_CNT_EN
    .if_perf_fetched   (if_perf_fetched),
    .if_perf_bubbles   (if_perf_bubbles),
`endif
    .if_id_nextpc      (if_id_nextpc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory image: two real instructions, then a tagged word per address
  function automatic logic [31:0] word(input logic [AW-1:0] a);
    if (a == AW'(0)) return 32'h2008_0005;
    if (a == AW'(1)) return 32'h2009_000A;
    return 32'hA000_0000 | 32'(a);
  endfunction

  assign mc_if_data = word(if_mc_addr);

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: one observation per falling edge while expectations are queued
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cmp("instruc", if_id_instruc, e.instr);
        cmp("nextpc", if_id_nextpc, e.npc);
        cmp("mc_en", 32'(if_mc_en), 32'(e.en));
        cmp("mc_addr", 32'(if_mc_addr), 32'(e.addr));
`ifdef IF_PERF_CNT_EN
        cmp("perf_fetched", if_perf_fetched, e.fetched);
        cmp("perf_bubbles", if_perf_bubbles, e.bubbles);
`endif
      end
    end
  end

  function automatic exp_t mk(input logic [31:0] ei, input logic [31:0] enpc, input logic een,
                              input logic [AW-1:0] ea, input int unsigned ef, input int unsigned eb);
    exp_t e;
    e.instr   = ei;
    e.npc     = enpc;
    e.en      = een;
    e.addr    = ea;
    e.fetched = 32'(ef);
    e.bubbles = 32'(eb);
    return e;
  endfunction

  // Drive one cycle; expectation describes state after the next rising edge
  task automatic step(input logic st, input logic sel, input logic [1:0] typ,
                      input logic [31:0] tgt, input logic vld,
                      input logic [31:0] ei, input logic [31:0] enpc, input logic een,
                      input logic [AW-1:0] ea, input int unsigned ef, input int unsigned eb);
    ex_if_stall       = st;
    id_if_selpcsource = sel;
    id_if_selpctype   = typ;
    id_if_pcimd2ext   = (typ == PCT_BR) ? tgt : 32'h2222_2220;
    id_if_rega        = (typ == PCT_JR) ? tgt : 32'h1111_1110;
    id_if_pcindex     = (typ == PCT_J)  ? tgt : 32'h3333_3330;
    mc_if_valid       = vld;
    @(posedge clock);
    exp_q.push_back(mk(ei, enpc, een, ea, ef, eb));
    #1;
  endtask

  initial begin
    reset = 1'b0;
    step(0, 0, 2'b00, 32'h0, 1'b1, NOP, 32'h0, 1'b0, AW'(0), 0, 0);
    exp_q.delete();
    // Reset state
    exp_q.push_back(mk(NOP, 32'h0, 1'b0, AW'(0), 0, 0));
    @(negedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;

    // Boot and back-to-back fetches
    step(0, 0, 2'b00, 32'h0,   1, NOP,           32'h0,   1, AW'(0),     0, 0);
    step(0, 0, 2'b00, 32'h0,   1, word(AW'(0)),  32'h4,   1, AW'(1),     1, 0);
    step(0, 0, 2'b00, 32'h0,   1, word(AW'(1)),  32'h8,   1, AW'(2),     2, 0);
    // Memory wait: two bubbles, address held
    step(0, 0, 2'b00, 32'h0,   0, NOP,           32'h8,   1, AW'(2),     2, 1);
    step(0, 0, 2'b00, 32'h0,   0, NOP,           32'h8,   1, AW'(2),     2, 2);
    step(0, 0, 2'b00, 32'h0,   1, word(AW'(2)),  32'hC,   1, AW'(3),     3, 2);
    step(0, 0, 2'b00, 32'h0,   1, word(AW'(3)),  32'h10,  1, AW'(4),     4, 2);
    // Stall with data returned: freeze, park word, drop request
    step(1, 0, 2'b00, 32'h0,   1, word(AW'(3)),  32'h10,  0, AW'(4),     4, 2);
    step(1, 0, 2'b00, 32'h0,   1, word(AW'(3)),  32'h10,  0, AW'(4),     4, 2);
    step(1, 0, 2'b00, 32'h0,   1, word(AW'(3)),  32'h10,  0, AW'(4),     4, 2);
    step(0, 0, 2'b00, 32'h0,   1, word(AW'(4)),  32'h14,  1, AW'(5),     5, 2);
    // Branch with delay slot completing in the same cycle
    step(0, 1, 2'b00, 32'h100, 1, word(AW'(5)),  32'h18,  1, AW'('h40),  6, 2);
    step(0, 0, 2'b00, 32'h0,   1, word(AW'('h40)), 32'h104, 1, AW'('h41), 7, 2);
    // jr while delay-slot fetch waits: redirect stays pending
    step(0, 1, 2'b01, 32'h200, 0, NOP,           32'h104, 1, AW'('h41),  7, 3);
    step(0, 0, 2'b00, 32'h0,   0, NOP,           32'h104, 1, AW'('h41),  7, 4);
    step(0, 0, 2'b00, 32'h0,   0, NOP,           32'h104, 1, AW'('h41),  7, 5);
    step(0, 0, 2'b00, 32'h0,   1, word(AW'('h41)), 32'h108, 1, AW'('h80), 8, 5);
    step(0, 0, 2'b00, 32'h0,   1, word(AW'('h80)), 32'h204, 1, AW'('h81), 9, 5);
    // Exception vector
    step(0, 1, 2'b11, 32'h0,   1, word(AW'('h81)), 32'h208, 1, AW'('h20), 10, 5);
    step(0, 0, 2'b00, 32'h0,   0, NOP,           32'h208, 1, AW'('h20),  10, 6);

    // Asynchronous reset in the middle of a wait
    @(negedge clock); #1;
    reset = 1'b0;
    #1;
    exp_q.push_back(mk(NOP, 32'h0, 1'b0, AW'(0), 0, 0));
    @(negedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;

    // j redirect, then a redirect presented under stall must be ignored
    step(0, 0, 2'b00, 32'h0,   1, NOP,           32'h0,   1, AW'(0),      0, 0);
    step(0, 1, 2'b10, 32'h3FC, 1, word(AW'(0)),  32'h4,   1, AW'('hFF),   1, 0);
    step(0, 0, 2'b00, 32'h0,   1, word(AW'('hFF)), 32'h400, 1, AW'('h100), 2, 0);
    step(1, 1, 2'b00, 32'h500, 1, word(AW'('hFF)), 32'h400, 0, AW'('h100), 2, 0);
    step(0, 0, 2'b00, 32'h0,   1, word(AW'('h100)), 32'h404, 1, AW'('h101), 3, 0);
    step(0, 0, 2'b00, 32'h0,   1, word(AW'('h101)), 32'h408, 1, AW'('h102), 4, 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(negedge clock); #1;
    end
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      $fatal(1, "scoreboard did not drain");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
